// File: rtl/rec_order_stream_if.sv
// Stream port from the receive unit to the PS: valid/ready handshake with TLAST framing.
interface rec_order_stream_if #(
   parameter int DATA_W = 25
);
   logic [DATA_W-1:0] axi_tdata;
   logic              axi_tvalid;
   logic              axi_tlast;
   logic              axi_tready;

   modport master (
      output axi_tdata,
      output axi_tvalid,
      output axi_tlast,
      input  axi_tready
   );

   modport slave (
      input  axi_tdata,
      input  axi_tvalid,
      input  axi_tlast,
      output axi_tready
   );
endinterface

// File: rtl/rec_order_stream.sv
// Receive unit: queues send orders, fetches IMGS_PER_ORDER samples per order from the
// sample buffer, streams them out through a one-deep output register with TLAST framing,
// and mirrors every fetched sample into a circular BRAM.
module rec_order_stream #(
   parameter int DATA_W         = 25,
   parameter int IMGS_PER_ORDER = 50,
   parameter int MAX_ORDERS     = 5,
   parameter int RAM_DEPTH      = 100,
   parameter int CNT_W          = $clog2(IMGS_PER_ORDER + 1),
   parameter int ORD_W          = $clog2(MAX_ORDERS + 1),
   parameter int ADDR_W         = $clog2(RAM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rec_en,
   input  logic              order_req,
   input  logic [DATA_W-1:0] buf_data,
   input  logic              buf_valid,
   output logic              buf_rd_en,
   rec_order_stream_if.master axis,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [ORD_W-1:0]  order_cnt,
   output logic              order_full,
   output logic              no_order,
   output logic              sending,
   output logic              order_drop,
   input  logic              err_clr
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [CNT_W-1:0]  fetch_cnt;
   logic [CNT_W-1:0]  sent_cnt;
   logic              fetch;
   logic              handshake;
   logic              finish;
   logic              order_done;
   logic              fetch_done;
   logic              order_inc;
   logic              order_lost;

   assign fetch      = buf_rd_en && buf_valid;
   assign handshake  = axis.axi_tvalid && axis.axi_tready;
   assign finish     = handshake && axis.axi_tlast;
   // the last beat of an order is also identified by count so the FSM does not hinge on tlast alone
   assign order_done = handshake && (sent_cnt == CNT_W'(IMGS_PER_ORDER - 1));
   assign fetch_done = (fetch_cnt == CNT_W'(IMGS_PER_ORDER));
   // a finishing order frees a slot in the same cycle, so a request is only lost when full without finish
   assign order_inc  = order_req && (!order_full || finish);
   assign order_lost = order_req && order_full && !finish;

   assign order_full = (order_cnt == ORD_W'(MAX_ORDERS));
   assign no_order   = (order_cnt == '0);
   assign sending    = (state != IDLE);
   assign ram_we     = fetch;
   assign ram_wdata  = buf_data;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state and buffer pop request
   always_comb begin
      state_nx  = state;
      buf_rd_en = 1'b0;
      case (state)
         IDLE: begin
            if (!no_order && rec_en) state_nx = STREAM;
         end
         STREAM: begin
            buf_rd_en = rec_en && (!axis.axi_tvalid || axis.axi_tready) && !fetch_done;
            // the final beat may already be accepted on the cycle the fetch count completes
            if (fetch_done) state_nx = order_done ? IDLE : DRAIN;
         end
         DRAIN: begin
            if (order_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Per-order fetch and sent counters, cleared while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         sent_cnt  <= '0;
      end else if (state == IDLE) begin
         fetch_cnt <= '0;
         sent_cnt  <= '0;
      end else begin
         if (fetch)     fetch_cnt <= fetch_cnt + 1'b1;
         if (handshake) sent_cnt  <= sent_cnt + 1'b1;
      end
   end

   // One-deep output register: load on fetch, empty on handshake without a refill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         axis.axi_tdata  <= '0;
         axis.axi_tvalid <= 1'b0;
         axis.axi_tlast  <= 1'b0;
      end else if (fetch) begin
         axis.axi_tdata  <= buf_data;
         axis.axi_tvalid <= 1'b1;
         axis.axi_tlast  <= (fetch_cnt == CNT_W'(IMGS_PER_ORDER - 1));
      end else if (handshake) begin
         axis.axi_tvalid <= 1'b0;
         axis.axi_tlast  <= 1'b0;
      end
   end

   // Circular BRAM write address, kept across orders
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      ram_addr <= '0;
      else if (fetch && ram_addr == ADDR_W'(RAM_DEPTH - 1)) ram_addr <= '0;
      else if (fetch)                                  ram_addr <= ram_addr + 1'b1;
   end

   // Pending order count and sticky drop flag (a new drop beats a coincident clear)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         order_cnt  <= '0;
         order_drop <= 1'b0;
      end else begin
         case ({order_inc, finish})
            2'b10:   order_cnt <= order_cnt + 1'b1;
            2'b01:   order_cnt <= order_cnt - 1'b1;
            default: order_cnt <= order_cnt;
         endcase
         if (order_lost)   order_drop <= 1'b1;
         else if (err_clr) order_drop <= 1'b0;
      end
   end

endmodule

// File: doc/rec_order_stream.md
Name: rec_order_stream

Overview:
- Parametrised successor to the PL receive unit. Queues user "send" orders, fetches IMGS_PER_ORDER processed samples per order from the sample buffer, and streams them to the PS over an AXI-Stream-style valid/ready port with TLAST framing.
- Mirrors each fetched sample into a circular BRAM.
- Adds back-pressure, an order-drop error flag and correct simultaneous order/finish accounting.

Parameters:
- DATA_W, 25, sample width in bits.
- IMGS_PER_ORDER, 50, samples per order (>=1).
- MAX_ORDERS, 5, order queue capacity (>=1).
- RAM_DEPTH, 100, BRAM entries; address wraps at RAM_DEPTH-1.
- CNT_W, $clog2(IMGS_PER_ORDER+1), derived sample counter width.
- ORD_W, $clog2(MAX_ORDERS+1), derived order counter width.
- ADDR_W, $clog2(RAM_DEPTH), derived BRAM address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rec_en  in  1  decoder enable; 0 pauses fetching
- order_req  in  1  one-cycle pulse per user send order
- buf_data  in  DATA_W  sample from buffer, valid with buf_valid
- buf_valid  in  1  buffer has a sample
- buf_rd_en  out  1  pop request to buffer; transfer when buf_rd_en && buf_valid
- axi_tdata  out  DATA_W  stream data to PS
- axi_tvalid  out  1  stream valid
- axi_tlast  out  1  last sample of current order
- axi_tready  in  1  PS ready
- ram_we  out  1  BRAM write strobe
- ram_addr  out  ADDR_W  BRAM write address
- ram_wdata  out  DATA_W  BRAM write data (= buf_data)
- order_cnt  out  ORD_W  pending orders, including the one in progress
- order_full  out  1  order_cnt == MAX_ORDERS
- no_order  out  1  order_cnt == 0 (1 during reset)
- sending  out  1  state != IDLE
- order_drop  out  1  sticky: an order_req was dropped
- err_clr  in  1  clears order_drop

Behaviour:
- Reset values (async): all counters, ram_addr, axi_tdata = 0; axi_tvalid, axi_tlast, order_drop = 0; state IDLE. no_order = 1, order_full = 0. Reset mid-order discards the order and any held beat.
- Order counter. inc = order_req && (!order_full || finish). dec = finish, where finish = axi_tvalid && axi_tready && axi_tlast.
  - inc && dec: count unchanged.
  - order_req when full and no finish that cycle: request dropped, order_drop set.
  - order_drop clears on err_clr. If set and clear coincide, set wins.
- State machine:
  - IDLE: go to STREAM when order_cnt > 0 && rec_en. Clear fetch_cnt and sent_cnt.
  - STREAM: buf_rd_en = rec_en && (!axi_tvalid || axi_tready) && fetch_cnt < IMGS_PER_ORDER. Go to DRAIN once fetch_cnt reaches IMGS_PER_ORDER.
  - DRAIN: buf_rd_en = 0. On finish, return to IDLE. One idle cycle between back-to-back orders is allowed.
- Fetch (buf_rd_en && buf_valid):
  - Next cycle: axi_tdata = buf_data, axi_tvalid = 1, fetch_cnt++.
  - axi_tlast = 1 on the beat where fetch_cnt becomes IMGS_PER_ORDER.
  - Same cycle as the fetch: ram_we = 1, ram_wdata = buf_data at ram_addr. Next cycle ram_addr increments; RAM_DEPTH-1 wraps to 0. ram_addr persists across orders.
- Output register is one deep:
  - axi_tvalid stays high and axi_tdata/axi_tlast stay stable until axi_tready.
  - Handshake with no new fetch: axi_tvalid drops next cycle.
  - Handshake with a fetch in the same cycle: throughput is 1 beat/clk.
  - sent_cnt++ per handshake.
- rec_en = 0 mid-order: fetching stops, the held beat can still complete, and the order resumes when rec_en returns. No samples are lost or duplicated.
- buf_valid = 0: no fetch, counters hold.
- Latency: buffer pop to axi_tvalid = 1 clk.

Test Plan:
- Defaults. One order_req, buf_valid = 1, axi_tready = 1, rec_en = 1 -> 50 consecutive beats with data = buffer sequence. axi_tlast only on beat 50. order_cnt 1->0. no_order returns to 1. sending high for the order duration.
- Back-pressure. axi_tready toggles 1 cycle on / 2 off -> tdata stable while tvalid && !tready. Exactly 50 handshakes; buf_rd_en never pops while the held beat is unaccepted.
- Queue. 6 order_req pulses while idle-blocked (rec_en = 0) -> order_cnt = 5, order_full = 1, order_drop = 1. err_clr clears order_drop. order_req coinciding with the last handshake at count 5 -> accepted, count stays 5, no drop.
- Wrap. 3 orders (150 writes), RAM_DEPTH = 100 -> ram_addr sequence 0..99, 0..49. ram_we count = 150.
- Pause. rec_en low for 10 cycles at beat 20 -> stream resumes at beat 21, total 50 beats, tlast once.
- Reset. rst_n asserted at beat 30 -> all outputs at reset values immediately. After release, a new order streams a full 50 beats.
